dht11_reader: RTL and testbench

- Single-wire DHT11 protocol controller.
- Periodically issues the start pulse, times the sensor's response and 40 data bits, and validates the checksum.
- Publishes integer humidity and temperature bytes that feed the bin2bcd/LCD display path in top.
- Runs on the system clock hclk and exposes an open-drain drive enable for the shared data pad.

---
 rtl/dht11_reader.sv | 221 ++++++++++++++++++++++
 tb/tb_dht11_reader.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_reader.sv
// DHT11 single-wire reader: issues the host start pulse, times the sensor
// response and 40 data bits, and publishes checksum-validated readings.
module dht11_reader #(
    parameter int CLK_HZ        = 12000000,
    parameter int POLL_MS       = 2000,
    parameter int START_LOW_US  = 18000,
    parameter int TIMEOUT_US    = 200,
    parameter int BIT_THRESH_US = 48
) (
    input  logic       hclk,
    input  logic       rst_n,
    input  logic       dht_in,
    output logic       dht_oe,
    input  logic       start,
    output logic [7:0] humidity,
    output logic [7:0] temperature,
    output logic       valid,
    output logic       err_checksum,
    output logic       err_timeout,
    output logic       busy
);

    localparam int US_DIV = (CLK_HZ / 1000000 > 0) ? CLK_HZ / 1000000 : 1;
    localparam int PRE_W  = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam int US_MAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int US_W   = $clog2(US_MAX + 1) + 1;
    localparam int MS_W   = (POLL_MS > 1) ? $clog2(POLL_MS + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START_LOW,
        RELEASE,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        CHECK
    } state_t;

    state_t state, state_d;

    logic             sync_meta, sync_cur, sync_prev;
    logic             rise, fall;
    logic [PRE_W-1:0] pre_cnt;
    logic             us_tick;
    logic [US_W-1:0]  us_cnt, us_now;
    logic [9:0]       poll_us;
    logic [MS_W-1:0]  poll_ms;
    logic             ms_wrap, poll_expire;
    logic [39:0]      shreg;
    logic [5:0]       bit_cnt;
    logic             bit_val;
    logic [7:0]       frame_b0, frame_b1, frame_b2, frame_b3, frame_b4, frame_sum;
    logic             checksum_ok;
    logic             waiting, shift_en, bit_clr;
    logic             valid_d, err_cs_d, err_to_d;

    // Pad level is asynchronous; two flops resolve metastability, the third
    // holds the previous settled level for edge detection. Idle line is high.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_cur  <= 1'b1;
            sync_prev <= 1'b1;
        end else begin
            sync_meta <= dht_in;
            sync_cur  <= sync_meta;
            sync_prev <= sync_cur;
        end
    end

    assign rise = ~sync_prev & sync_cur;
    assign fall = sync_prev & ~sync_cur;

    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n)       pre_cnt <= '0;
        else if (us_tick) pre_cnt <= '0;
        else              pre_cnt <= pre_cnt + 1'b1;
    end

    assign us_tick = (pre_cnt == PRE_W'(US_DIV - 1));

    // Microseconds spent in the current state, counting the tick of this cycle.
    assign us_now = us_cnt + US_W'(us_tick);

    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n)                                 us_cnt <= '0;
        else if (state_d != state || state == IDLE) us_cnt <= '0;
        else if (us_tick)                           us_cnt <= us_now;
    end

    assign ms_wrap     = us_tick && (poll_us == 10'd999);
    assign poll_expire = ms_wrap && (poll_ms == MS_W'(POLL_MS - 1));

    // Poll interval restarts from zero every time the controller returns to IDLE.
    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            poll_us <= '0;
            poll_ms <= '0;
        end else if (state != IDLE || state_d != IDLE) begin
            poll_us <= '0;
            poll_ms <= '0;
        end else if (ms_wrap) begin
            poll_us <= '0;
            poll_ms <= poll_ms + 1'b1;
        end else if (us_tick) begin
            poll_us <= poll_us + 10'd1;
        end
    end

    assign bit_val     = (us_now > US_W'(BIT_THRESH_US));
    assign frame_b0    = shreg[39:32];
    assign frame_b1    = shreg[31:24];
    assign frame_b2    = shreg[23:16];
    assign frame_b3    = shreg[15:8];
    assign frame_b4    = shreg[7:0];
    assign frame_sum   = frame_b0 + frame_b1 + frame_b2 + frame_b3;
    assign checksum_ok = (frame_sum == frame_b4);

    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // NOTE: every signal driven here gets a default first so no path through
    // the case leaves it unassigned and a latch is never inferred.
    always_comb begin
        state_d  = state;
        waiting  = 1'b0;
        shift_en = 1'b0;
        bit_clr  = 1'b0;
        valid_d  = 1'b0;
        err_cs_d = 1'b0;
        err_to_d = 1'b0;
        case (state)
            IDLE: begin
                if (start || poll_expire) state_d = START_LOW;
            end
            START_LOW: begin
                if (us_now >= US_W'(START_LOW_US)) state_d = RELEASE;
            end
            RELEASE: begin
                waiting = 1'b1;
                if (fall) state_d = RESP_LOW;
            end
            RESP_LOW: begin
                waiting = 1'b1;
                if (rise) state_d = RESP_HIGH;
            end
            RESP_HIGH: begin
                waiting = 1'b1;
                if (fall) begin
                    state_d = BIT_LOW;
                    bit_clr = 1'b1;
                end
            end
            BIT_LOW: begin
                waiting = 1'b1;
                if (rise) state_d = BIT_HIGH;
            end
            BIT_HIGH: begin
                waiting = 1'b1;
                if (fall) begin
                    shift_en = 1'b1;
                    state_d  = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (checksum_ok) valid_d  = 1'b1;
                else             err_cs_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // An awaited edge arriving on the timeout cycle still wins.
        if (waiting && state_d == state && us_now >= US_W'(TIMEOUT_US)) begin
            state_d  = IDLE;
            err_to_d = 1'b1;
        end
    end

    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (bit_clr) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shreg   <= {shreg[38:0], bit_val};
            bit_cnt <= bit_cnt + 6'd1;
        end
    end

    // Pad enable and status pulses are registered so the pad sees no decode glitches.
    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            dht_oe       <= 1'b0;
            valid        <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            humidity     <= '0;
            temperature  <= '0;
        end else begin
            dht_oe       <= (state_d == START_LOW);
            valid        <= valid_d;
            err_checksum <= err_cs_d;
            err_timeout  <= err_to_d;
            if (valid_d) begin
                humidity    <= frame_b0;
                temperature <= frame_b2;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dht11_reader.sv
// Self-checking bench for dht11_reader: behavioural DHT11 sensor on the pad
// and a byte-level reference model of decode and checksum.
`timescale 1ns/1ps
module tb_dht11_reader;

    localparam int CLK_HZ        = 1000000;
    localparam int POLL_MS       = 5;
    localparam int START_LOW_US  = 100;
    localparam int TIMEOUT_US    = 200;
    localparam int BIT_THRESH_US = 48;
    localparam int POLL_CYC      = POLL_MS * 1000;

    logic       hclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sens_low = 1'b0;
    logic       dht_in, dht_oe, valid, err_checksum, err_timeout, busy;
    logic [7:0] humidity, temperature;

    int         vectors = 0;
    int         miscompares = 0;
    int         hi_us[40];
    logic [7:0] model_hum = 8'd0;
    logic [7:0] model_temp = 8'd0;
    logic       probe_oe = 1'b0;
    logic       probe_busy = 1'b0;

    assign dht_in = !(dht_oe || sens_low);

    always #500 hclk = ~hclk;

    dht11_reader #(
        .CLK_HZ       (CLK_HZ),
        .POLL_MS      (POLL_MS),
        .START_LOW_US (START_LOW_US),
        .TIMEOUT_US   (TIMEOUT_US),
        .BIT_THRESH_US(BIT_THRESH_US)
    ) dut (
        .hclk        (hclk),
        .rst_n       (rst_n),
        .dht_in      (dht_in),
        .dht_oe      (dht_oe),
        .start       (start),
        .humidity    (humidity),
        .temperature (temperature),
        .valid       (valid),
        .err_checksum(err_checksum),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    task automatic hold(input logic level, input int n);
        sens_low = !level;
        repeat (n) @(negedge hclk);
    endtask

    task automatic wait_oe(input logic level, input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < budget) begin
            @(negedge hclk);
            cycles++;
            if (dht_oe === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pulse(input int budget, output logic [2:0] pv, output int width,
                              output int waited, output logic busy_before, output logic busy_at,
                              output logic [7:0] hum_at, output logic [7:0] temp_at);
        logic prev_busy;
        pv = '0; width = 0; waited = 0;
        busy_before = 1'b0; busy_at = 1'b0; hum_at = '0; temp_at = '0;
        prev_busy = busy;
        while (waited < budget) begin
            @(negedge hclk);
            waited++;
            if (valid || err_checksum || err_timeout) begin
                pv          = {valid, err_checksum, err_timeout};
                busy_before = prev_busy;
                busy_at     = busy;
                hum_at      = humidity;
                temp_at     = temperature;
                width       = 1;
                while (width < 8) begin
                    @(negedge hclk);
                    if (!(valid || err_checksum || err_timeout)) break;
                    width++;
                end
                break;
            end
            prev_busy = busy;
        end
    endtask

    // Sensor: waits for the host start pulse, then answers with response and 40 bits.
    task automatic sensor_session(input int start_at_bit, input int stop_at_bit);
        int c;
        bit ok;
        wait_oe(1'b1, POLL_CYC + 100, c, ok);
        if (!ok) return;
        wait_oe(1'b0, START_LOW_US + 100, c, ok);
        if (!ok) return;
        hold(1'b1, 20);
        hold(1'b0, 80);
        hold(1'b1, 80);
        for (int i = 0; i < 40; i++) begin
            if (i == stop_at_bit) begin
                sens_low = 1'b1;
                return;
            end
            hold(1'b0, 50);
            if (i == start_at_bit) begin
                sens_low = 1'b0;
                start    = 1'b1;
                @(negedge hclk);
                start      = 1'b0;
                probe_oe   = dht_oe;
                probe_busy = busy;
                hold(1'b1, hi_us[i] - 1);
            end else begin
                hold(1'b1, hi_us[i]);
            end
        end
        hold(1'b0, 50);
        sens_low = 1'b0;
    endtask

    // Bit high times: fixed when hi0/hi1 > 0, otherwise random on the proper side of 48 us.
    task automatic set_frame(input logic [39:0] f, input int hi0, input int hi1);
        for (int i = 0; i < 40; i++) begin
            if (f[39-i]) hi_us[i] = (hi1 > 0) ? hi1 : int'($urandom_range(80, 49));
            else         hi_us[i] = (hi0 > 0) ? hi0 : int'($urandom_range(48, 20));
        end
    endtask

    // Reference: decode bytes from the pulse widths the sensor will send.
    task automatic model_expect(output logic [2:0] exp_pv);
        int b[5];
        int sum;
        for (int k = 0; k < 5; k++) b[k] = 0;
        for (int i = 0; i < 40; i++) b[i/8] = b[i/8] * 2 + ((hi_us[i] > BIT_THRESH_US) ? 1 : 0);
        sum = (b[0] + b[1] + b[2] + b[3]) % 256;
        if (sum == b[4]) begin
            exp_pv     = 3'b100;
            model_hum  = 8'(b[0]);
            model_temp = 8'(b[2]);
        end else begin
            exp_pv = 3'b010;
        end
    endtask

    task automatic do_read(input int start_bit, output logic oe_next, output logic [2:0] pv,
                           output int width, output logic busy_before, output logic busy_at,
                           output logic [7:0] hum_at, output logic [7:0] temp_at);
        int waited;
        @(negedge hclk);
        start = 1'b1;
        @(negedge hclk);
        start   = 1'b0;
        oe_next = dht_oe;
        fork
            sensor_session(start_bit, 40);
            wait_pulse(8000, pv, width, waited, busy_before, busy_at, hum_at, temp_at);
        join
    endtask

    task automatic test_reset();
        int  c;
        bit  ok;
        repeat (5) @(negedge hclk);
        vectors++;
        if ({dht_oe, valid, err_checksum, err_timeout, busy, humidity, temperature} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0",
                     {dht_oe, valid, err_checksum, err_timeout, busy, humidity, temperature});
        end
        rst_n = 1'b1;
        wait_oe(1'b1, POLL_CYC + 100, c, ok);
        vectors++;
        if (!ok || c < POLL_CYC - 3 || c > POLL_CYC + 3) begin
            miscompares++;
            $display("FAIL first_poll_delay: got %0d cycles (seen=%0d) want %0d", c, ok, POLL_CYC);
        end
        wait_oe(1'b0, START_LOW_US + 100, c, ok);
        vectors++;
        if (!ok || c != START_LOW_US) begin
            miscompares++;
            $display("FAIL start_low_width: got %0d (seen=%0d) want %0d", c, ok, START_LOW_US);
        end
    endtask

    task automatic test_timeout();
        logic [2:0] pv;
        int         w, waited, c;
        bit         ok;
        logic       bb, ba;
        logic [7:0] h, t;
        wait_pulse(TIMEOUT_US + 50, pv, w, waited, bb, ba, h, t);
        vectors++;
        if (pv !== 3'b001) begin
            miscompares++;
            $display("FAIL timeout_pulse: got %b want 001", pv);
        end
        vectors++;
        if (waited != TIMEOUT_US) begin
            miscompares++;
            $display("FAIL timeout_delay: got %0d want %0d", waited, TIMEOUT_US);
        end
        vectors++;
        if (w != 1 || ba !== 1'b0 || h !== 8'd0 || t !== 8'd0) begin
            miscompares++;
            $display("FAIL timeout_state: width=%0d busy=%b hum=%0d temp=%0d want 1 0 0 0", w, ba, h, t);
        end
        wait_oe(1'b1, POLL_CYC + 100, c, ok);
        vectors++;
        if (!ok || c < POLL_CYC - 5 || c > POLL_CYC + 5) begin
            miscompares++;
            $display("FAIL repoll_delay: got %0d (seen=%0d) want about %0d", c, ok, POLL_CYC);
        end
        wait_oe(1'b0, START_LOW_US + 100, c, ok);
        wait_pulse(TIMEOUT_US + 50, pv, w, waited, bb, ba, h, t);
        vectors++;
        if (pv !== 3'b001) begin
            miscompares++;
            $display("FAIL second_timeout: got %b want 001", pv);
        end
    endtask

    task automatic test_good_frame();
        logic       oe_next, bb, ba;
        logic [2:0] pv, exp_pv;
        int         w;
        logic [7:0] h, t;
        set_frame(40'h37_00_19_00_50, 26, 70);
        model_expect(exp_pv);
        do_read(-1, oe_next, pv, w, bb, ba, h, t);
        vectors++;
        if (oe_next !== 1'b1) begin
            miscompares++;
            $display("FAIL start_to_oe: got %b want 1", oe_next);
        end
        vectors++;
        if (pv !== exp_pv || w != 1) begin
            miscompares++;
            $display("FAIL good_pulse: got %b width %0d want %b width 1", pv, w, exp_pv);
        end
        vectors++;
        if (h !== model_hum || t !== model_temp || h !== 8'd55 || t !== 8'd25) begin
            miscompares++;
            $display("FAIL good_values: got %0d/%0d want %0d/%0d", h, t, model_hum, model_temp);
        end
        vectors++;
        if (bb !== 1'b1 || ba !== 1'b0) begin
            miscompares++;
            $display("FAIL good_busy: got before=%b at=%b want 1 0", bb, ba);
        end
    endtask

    task automatic test_bad_checksum();
        logic       oe_next, bb, ba;
        logic [2:0] pv, exp_pv;
        int         w;
        logic [7:0] h, t;
        set_frame(40'h37_00_19_00_51, 26, 70);
        model_expect(exp_pv);
        do_read(-1, oe_next, pv, w, bb, ba, h, t);
        vectors++;
        if (pv !== exp_pv || pv !== 3'b010 || w != 1) begin
            miscompares++;
            $display("FAIL bad_cs_pulse: got %b width %0d want 010 width 1", pv, w);
        end
        vectors++;
        if (h !== 8'd55 || t !== 8'd25) begin
            miscompares++;
            $display("FAIL bad_cs_hold: got %0d/%0d want 55/25", h, t);
        end
    endtask

    task automatic test_bit_boundary();
        logic       oe_next, bb, ba;
        logic [2:0] pv, exp_pv;
        int         w;
        logic [7:0] h, t;
        set_frame(40'h01_00_01_00_02, BIT_THRESH_US, BIT_THRESH_US + 1);
        model_expect(exp_pv);
        do_read(-1, oe_next, pv, w, bb, ba, h, t);
        vectors++;
        if (pv !== exp_pv || w != 1) begin
            miscompares++;
            $display("FAIL boundary_pulse: got %b width %0d want %b", pv, w, exp_pv);
        end
        vectors++;
        if (h !== 8'd1 || t !== 8'd1) begin
            miscompares++;
            $display("FAIL boundary_values: got %0d/%0d want 1/1", h, t);
        end
    endtask

    task automatic test_random_frames();
        logic       oe_next, bb, ba;
        logic [2:0] pv, exp_pv;
        int         w;
        logic [7:0] h, t, b0, b1, b2, b3, b4;
        for (int n = 0; n < 4; n++) begin
            b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
            b4 = b0 + b1 + b2 + b3;
            if ($urandom_range(2, 0) == 0) b4 = b4 ^ 8'($urandom_range(255, 1));
            set_frame({b0, b1, b2, b3, b4}, 0, 0);
            model_expect(exp_pv);
            do_read(-1, oe_next, pv, w, bb, ba, h, t);
            vectors++;
            if (pv !== exp_pv || w != 1) begin
                miscompares++;
                $display("FAIL random_pulse[%0d]: got %b width %0d want %b", n, pv, w, exp_pv);
            end
            vectors++;
            if (h !== model_hum || t !== model_temp) begin
                miscompares++;
                $display("FAIL random_values[%0d]: got %0d/%0d want %0d/%0d", n, h, t, model_hum, model_temp);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic       oe_next, bb, ba, extra;
        logic [2:0] pv, exp_pv;
        int         w;
        logic [7:0] h, t;
        set_frame(40'h37_00_19_00_50, 26, 70);
        model_expect(exp_pv);
        do_read(10, oe_next, pv, w, bb, ba, h, t);
        vectors++;
        if (probe_busy !== 1'b1 || probe_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_start: got busy=%b oe=%b want 1 0", probe_busy, probe_oe);
        end
        vectors++;
        if (pv !== exp_pv || h !== model_hum || t !== model_temp) begin
            miscompares++;
            $display("FAIL busy_start_frame: got %b %0d/%0d want %b %0d/%0d",
                     pv, h, t, exp_pv, model_hum, model_temp);
        end
        extra = 1'b0;
        repeat (20) begin
            @(negedge hclk);
            if (dht_oe) extra = 1'b1;
        end
        vectors++;
        if (extra !== 1'b0) begin
            miscompares++;
            $display("FAIL start_queued: got oe=%b after frame want 0", extra);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic       oe_next, bb, ba;
        logic [2:0] pv, exp_pv;
        int         w;
        logic [7:0] h, t;
        set_frame(40'h2A_00_14_00_3E, 26, 70);
        @(negedge hclk);
        start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
        sensor_session(-1, 20);
        repeat (10) @(negedge hclk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_frame_busy: got %b want 1", busy);
        end
        #100 rst_n = 1'b0;
        #1;
        vectors++;
        if ({dht_oe, valid, err_checksum, err_timeout, busy, humidity, temperature} !== 21'd0) begin
            miscompares++;
            $display("FAIL mid_frame_reset: got %h want 0",
                     {dht_oe, valid, err_checksum, err_timeout, busy, humidity, temperature});
        end
        model_hum  = 8'd0;
        model_temp = 8'd0;
        sens_low   = 1'b0;
        @(negedge hclk);
        rst_n = 1'b1;
        @(negedge hclk);
        start = 1'b1;
        @(negedge hclk);
        start = 1'b0;
        repeat (10) @(negedge hclk);
        vectors++;
        if (dht_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL start_low_active: got %b want 1", dht_oe);
        end
        #100 rst_n = 1'b0;
        #1;
        vectors++;
        if (dht_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL oe_async_reset: got %b want 0", dht_oe);
        end
        @(negedge hclk);
        rst_n = 1'b1;
        model_expect(exp_pv);
        do_read(-1, oe_next, pv, w, bb, ba, h, t);
        vectors++;
        if (pv !== exp_pv || pv !== 3'b100 || h !== 8'd42 || t !== 8'd20) begin
            miscompares++;
            $display("FAIL post_reset_read: got %b %0d/%0d want 100 42/20", pv, h, t);
        end
    endtask

    initial begin
        #(95_000_000);
        $display("FAIL watchdog: got no finish want finish before 95000 cycles");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_timeout();
        test_good_frame();
        test_bad_checksum();
        test_bit_boundary();
        test_random_frames();
        test_start_ignored();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
